// File: rtl/pulse_stretch_multi.sv
// Multi-channel debug pulse stretcher with edge/level trigger and missed flags.
// Define PULSE_STRETCH_SYNC_EN to add a 2-flop input synchroniser per channel.
module pulse_stretch_multi #(
   parameter int NUM_CH      = 8,
   parameter int CNT_W       = 8,
   parameter int DEFAULT_LEN = 10
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic [NUM_CH-1:0] in_pulse,
   input  logic [CNT_W-1:0]  stretch_len,
   input  logic              edge_mode,
   input  logic              retrigger,
   input  logic              clear_missed,
   output logic [NUM_CH-1:0] out_pulse,
   output logic [NUM_CH-1:0] missed,
   output logic              active_any
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] DEF_LEN = CNT_W'(DEFAULT_LEN);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [NUM_CH-1:0] in_s;
   logic [NUM_CH-1:0] in_d_q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] trig;
   logic [CNT_W-1:0]  len_eff;

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] missed_q;
   logic [NUM_CH-1:0] missed_d;

`ifdef PULSE_STRETCH_SYNC_EN
   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_pulse;
         sync2_q <= sync1_q;
      end
   end

   assign in_s = sync2_q;
`else
   assign in_s = in_pulse;
`endif

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         in_d_q <= '0;
      end else begin
         in_d_q <= in_s;
      end
   end

   assign rise    = in_s & ~in_d_q;
   assign trig    = edge_mode ? rise : in_s;
   assign len_eff = (stretch_len == '0) ? DEF_LEN : stretch_len;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         unique case (state_q[i])
            ST_IDLE: begin
               if (trig[i]) begin
                  state_d[i] = ST_ACTIVE;
                  cnt_d[i]   = len_eff;
               end
            end
            ST_ACTIVE: begin
               if (trig[i] && retrigger) begin
                  cnt_d[i] = len_eff;
               end else if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - ONE;
               end else if (trig[i]) begin
                  // expiring one-shot reloads back-to-back with no gap
                  cnt_d[i] = len_eff;
               end else begin
                  state_d[i] = ST_IDLE;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      missed_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         missed_d[i] = (rise[i] && state_q[i] == ST_ACTIVE
                        && cnt_q[i] != '0 && !retrigger)
                     | (missed_q[i] & ~clear_missed);
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         missed_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         missed_q <= missed_d;
      end
   end

   always_comb begin
      out_pulse = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         out_pulse[i] = (state_q[i] == ST_ACTIVE);
      end
   end

   assign missed     = missed_q;
   assign active_any = |out_pulse;

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Scoreboard bench for pulse_stretch_multi: directed windows, queued expectations.
module tb_pulse_stretch_multi;

`ifdef PULSE_STRETCH_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic       clk = 1'b0;
   logic       nReset;
   logic [7:0] in_pulse;
   logic [7:0] stretch_len;
   logic       edge_mode;
   logic       retrigger;
   logic       clear_missed;
   logic [7:0] out_pulse;
   logic [7:0] missed;
   logic       active_any;

   typedef struct {
      int         due;
      logic [7:0] o;
      logic [7:0] m;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   total  = 0;
   int   nfail  = 0;

   pulse_stretch_multi dut (
      .clk          (clk),
      .nReset       (nReset),
      .in_pulse     (in_pulse),
      .stretch_len  (stretch_len),
      .edge_mode    (edge_mode),
      .retrigger    (retrigger),
      .clear_missed (clear_missed),
      .out_pulse    (out_pulse),
      .missed       (missed),
      .active_any   (active_any)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] req);
      total = total + 1;
      if (act !== req) begin
         nfail = nfail + 1;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, req);
      end
   endtask

   task automatic chk_all(input string nm, input logic [7:0] eo,
                          input logic [7:0] em);
      chk({nm, ".out"}, out_pulse, eo);
      chk({nm, ".missed"}, missed, em);
      chk({nm, ".any"}, {7'd0, active_any}, {7'd0, |eo});
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_t e;
         e = q.pop_front();
         chk_all(e.nm, e.o, e.m);
      end
   end

   function automatic logic [7:0] win(input int u, input int lo,
                                      input int hi, input logic [7:0] m);
      return (u >= lo && u <= hi) ? m : 8'h00;
   endfunction

   task automatic step(input logic [7:0] inp, input logic clr,
                       input logic [7:0] eo, input logic [7:0] em,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      in_pulse     = inp;
      clear_missed = clr;
      e.due = cyc + 1;
      e.o   = eo;
      e.m   = em;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      if (q.size() != 0) begin
         total = total + 1;
         nfail = nfail + 1;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_reset(input string nm);
      drain();
      #1;
      nReset       = 1'b0;
      in_pulse     = '0;
      clear_missed = 1'b0;
      #1;
      chk_all(nm, 8'h00, 8'h00);
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;
   endtask

   initial begin
      int u;
      nReset       = 1'b0;
      in_pulse     = '0;
      stretch_len  = '0;
      edge_mode    = 1'b0;
      retrigger    = 1'b0;
      clear_missed = 1'b0;
      #12;
      chk_all("por", 8'h00, 8'h00);
      @(negedge clk);
      nReset = 1'b1;

      // default length, single strobe on ch0
      stretch_len = 8'd0; edge_mode = 1'b0; retrigger = 1'b0;
      for (int t = 0; t <= 14 + D; t++) begin
         u = t - D;
         step((t == 0) ? 8'h01 : 8'h00, 1'b0,
              win(u, 0, 10, 8'h01), 8'h00, "s1");
      end
      do_reset("rst1");

      // retrigger reload on ch3
      stretch_len = 8'd4; retrigger = 1'b1;
      for (int t = 0; t <= 10 + D; t++) begin
         u = t - D;
         step((t == 0 || t == 3) ? 8'h08 : 8'h00, 1'b0,
              win(u, 0, 7, 8'h08), 8'h00, "s2");
      end
      do_reset("rst2");

      // one-shot miss, clear, clear colliding with a new miss
      stretch_len = 8'd4; retrigger = 1'b0;
      for (int t = 0; t <= 18 + D; t++) begin
         u = t - D;
         step((t == 0 || t == 3 || t == 12 || t == 14) ? 8'h08 : 8'h00,
              (u == 10 || u == 14),
              win(u, 0, 4, 8'h08) | win(u, 12, 16, 8'h08),
              win(u, 3, 9, 8'h08) | win(u, 14, 999, 8'h08), "s3");
      end
      do_reset("rst3");

      // held level on ch5, edge trigger
      stretch_len = 8'd3; edge_mode = 1'b1; retrigger = 1'b0;
      for (int t = 0; t <= 23 + D; t++) begin
         u = t - D;
         step((t < 20) ? 8'h20 : 8'h00, 1'b0,
              win(u, 0, 3, 8'h20), 8'h00, "s4e");
      end
      do_reset("rst4");

      // held level on ch5, level trigger with retrigger
      edge_mode = 1'b0; retrigger = 1'b1;
      for (int t = 0; t <= 25 + D; t++) begin
         u = t - D;
         step((t < 20) ? 8'h20 : 8'h00, 1'b0,
              win(u, 0, 22, 8'h20), 8'h00, "s4l");
      end
      do_reset("rst5");

      // all channels active with misses, reset lands at cnt == 6
      stretch_len = 8'd0; edge_mode = 1'b0; retrigger = 1'b0;
      for (int t = 0; t <= 4 + D; t++) begin
         u = t - D;
         step((t == 0 || t == 2) ? 8'hFF : 8'h00, 1'b0,
              win(u, 0, 4, 8'hFF), win(u, 2, 999, 8'hFF), "s5");
      end
      do_reset("midrst");
      for (int t = 0; t <= 5 + D; t++) begin
         step(8'h00, 1'b0, 8'h00, 8'h00, "post");
      end
      drain();

      $display("%0d/%0d checks passed", total - nfail, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, want finish");
      $fatal(1);
   end

endmodule
